// File: rtl/dc4b_pkg.sv
// dc4b_pkg: shared state encoding and default width for the dc4b countdown timer
package dc4b_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/dc4b_timer.sv
// dc4b_timer: loadable down-counting timer with start/pause/abort control and optional auto-reload
module dc4b_timer
  import dc4b_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
  logic tc_q, tc_d;
  logic go;
  always_comb begin
    go       = start && (load_val != '0);
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d  = go ? RUN : state_q;
          cnt_d    = go ? load_val : cnt_q;
          reload_d = go ? load_val : reload_q;
        end
        RUN: begin
          if (pause) state_d = PAUSED;
          else if (cnt_q > WIDTH'(1)) cnt_d = cnt_q - WIDTH'(1);
          else if (cnt_q == WIDTH'(1)) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end else if (auto_reload) cnt_d = reload_q;
          else state_d = DONE;
        end
        PAUSED:  state_d = pause ? PAUSED : RUN;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end
  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN) || (state_q == PAUSED);
  assign done = (state_q == DONE);
endmodule
